fifo_row_sequencer: RTL and testbench
=====================================

# fifo_row_sequencer

Row-burst controller for the configurable block FIFO that sits between two convolution pipeline stages. It latches a per-layer configuration and drives the FIFO's `S_count`/`M_count` thresholds. It admits producer write bursts only when `S_Ready` guarantees space, and issues consumer read bursts only when `M_Ready` guarantees data. At end of layer it pulses `Next_Reg` to flush the FIFO, then reports completion.

## Interface
- `ADDR_BITS`, 10: FIFO address width. Counts and lengths are `ADDR_BITS+1` bits wide.
- `ROW_BITS`, 12: width of the row counters.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle pulse that begins a layer. Ignored while `busy`=1.
- `cfg_rows`  in  ROW_BITS: rows per layer, sampled on accepted `start`.
- `cfg_wr_len`  in  ADDR_BITS+1: words written per row, sampled on `start`.
- `cfg_rd_len`  in  ADDR_BITS+1: words read per row, sampled on `start`.
- `S_count`  out  ADDR_BITS+1: space threshold driven to the FIFO (latched `cfg_wr_len`).
- `M_count`  out  ADDR_BITS+1: data threshold driven to the FIFO (latched `cfg_rd_len`).
- `S_Ready`  in  1: FIFO has room for `S_count` words (registered in the FIFO).
- `M_Ready`  in  1: FIFO holds at least `M_count` words (registered in the FIFO).
- `wr_req`  out  1: producer is granted a row burst.
- `wr_valid`  in  1: producer word strobe.
- `fifo_wr_en`  out  1: FIFO write enable.
- `rd_en`  out  1: FIFO read enable.
- `rd_valid`  out  1: FIFO `dout` is valid this cycle (`rd_en` delayed by 1).
- `Next_Reg`  out  1: one-cycle FIFO flush pulse.
- `busy`  out  1: layer in progress.
- `done`  out  1: one-cycle layer-complete pulse.

## Operation
- Top FSM states are IDLE, RUN, FLUSH and DONE.
- IDLE → RUN on `start`. Config is latched on the same edge.
- If any of `cfg_rows`, `cfg_wr_len` or `cfg_rd_len` is 0, IDLE → FLUSH directly on `start` instead.
- RUN → FLUSH when both engines have completed `cfg_rows` rows.
- FLUSH asserts `Next_Reg`=1 for 1 cycle, then goes to DONE.
- DONE asserts `done`=1 for 1 cycle, then goes to IDLE.
- `busy`=1 in RUN, FLUSH and DONE. `busy` deasserts in the same cycle `done` is high? No: `busy`=0 when the state is IDLE, and `done` is high in the DONE state.
- The write engine runs in RUN with states W_WAIT, W_BURST and W_SETTLE:
  - W_WAIT → W_BURST when `S_Ready`=1.
  - In W_BURST: `wr_req`=1 and `fifo_wr_en`=`wr_valid`. The word counter increments on each `wr_valid`.
  - At the `cfg_wr_len`-th word: row counter +1, then go to W_SETTLE.
  - W_SETTLE lasts exactly 2 cycles, covering the FIFO's registered count/ready lag. It then returns to W_WAIT, or to W_DONE if the row count equals `cfg_rows`.
- The read engine runs in RUN with states R_WAIT, R_BURST, R_SETTLE and R_DONE, symmetric to the write engine:
  - R_WAIT → R_BURST when `M_Ready`=1.
  - In R_BURST, `rd_en`=1 on `cfg_rd_len` consecutive cycles with no gaps.
  - Then 2 cycles of R_SETTLE.
- The two engines run concurrently and independently.
- Contract on the caller: `cfg_rd_len` ≤ `cfg_wr_len` and total reads ≤ total writes. The block does not check this; a violation stalls the read engine in R_WAIT.
- Counters are `ADDR_BITS+1` and `ROW_BITS` wide and never wrap within a legal layer.

## Timing
- Reset values: `S_count`=0, `M_count`=0, `wr_req`=0, `fifo_wr_en`=0, `rd_en`=0, `rd_valid`=0, `Next_Reg`=0, `busy`=0, `done`=0. All FSMs return to IDLE.
- `start` at edge N: `busy`=1 and `S_count`/`M_count` valid from cycle N+1, and both engines are in W_WAIT/R_WAIT.
- The earliest `wr_req` or `rd_en` is cycle N+2, given that `S_Ready`/`M_Ready` are already high in cycle N+1.
- `S_Ready`/`M_Ready` are sampled only in the WAIT states. Changes during BURST or SETTLE are ignored.
- `fifo_wr_en` is combinational from `wr_valid` and the W_BURST state, so there is zero added latency.
- `rd_valid` follows `rd_en` by exactly 1 cycle. The final `rd_valid` may coincide with the first R_SETTLE cycle.
- Last engine enters DONE at cycle K → `Next_Reg`=1 in cycle K+1 → `done`=1 in cycle K+2 → IDLE in cycle K+3.
- A new `start` is accepted in IDLE only, never in the same cycle as `done`.
- `rst_n` low mid-burst: all outputs drop to reset values immediately (asynchronously). Any partial row is abandoned. The FIFO is flushed by the system reset, not by `Next_Reg`.

## Test plan
- Basic layer: `cfg_rows`=2, `cfg_wr_len`=4, `cfg_rd_len`=4, ready inputs held high, `wr_valid` continuous → 8 `fifo_wr_en` and 8 `rd_en` in bursts of 4, a 2-cycle gap after each burst, then `Next_Reg` for 1 cycle followed by `done` for 1 cycle.
- Backpressure: `S_Ready`=0 for 10 cycles after `start` → `wr_req` stays 0 throughout. `wr_req` rises 1 cycle after `S_Ready` rises. `M_Ready`=0 similarly holds `rd_en`=0.
- Producer gaps: `cfg_wr_len`=5, `wr_valid` toggling 1,0,1,… → `wr_req` is held high until the 5th accepted word. `fifo_wr_en` equals `wr_valid` cycle-by-cycle.
- Zero config: `cfg_rows`=0 → no `wr_req`/`rd_en`, `Next_Reg` at N+1, `done` at N+2. Repeat with `cfg_wr_len`=0 → same response.
- Start while busy: a second `start` with different config mid-layer → ignored. `S_count`/`M_count` unchanged and the row totals match the first config.
- Reset mid-operation: `rst_n`=0 during W_BURST and R_BURST → all outputs at reset values in the same cycle. After release, a fresh `start` completes the basic layer correctly.

Source files
------------

// File: rtl/fifo_row_sequencer.sv
// -----------------------------------------------------------------------------
// fifo_row_sequencer
//   Row-burst controller for the block FIFO between two convolution stages.
//   Latches a per-layer config, drives the FIFO space/data thresholds, grants
//   producer write bursts when S_Ready promises room and issues consumer read
//   bursts when M_Ready promises data. At end of layer it pulses Next_Reg to
//   flush the FIFO, then pulses done.
//
// Ports
//   clk, rst_n              clock / async active-low reset
//   start                   layer start pulse (ignored while busy)
//   cfg_rows/wr_len/rd_len  layer config, sampled on accepted start
//   S_count, M_count        latched write/read burst lengths to the FIFO
//   S_Ready, M_Ready        FIFO space/data ready (registered in the FIFO)
//   wr_req                  producer granted a row burst
//   wr_valid                producer word strobe
//   fifo_wr_en              FIFO write enable
//   rd_en, rd_valid         FIFO read enable, and dout-valid one cycle later
//   Next_Reg                one-cycle FIFO flush pulse
//   busy, done              layer in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module fifo_row_sequencer #(
    parameter int ADDR_BITS = 10,
    parameter int ROW_BITS  = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ROW_BITS-1:0] cfg_rows,
    input  logic [ADDR_BITS:0]  cfg_wr_len,
    input  logic [ADDR_BITS:0]  cfg_rd_len,
    output logic [ADDR_BITS:0]  S_count,
    output logic [ADDR_BITS:0]  M_count,
    input  logic                S_Ready,
    input  logic                M_Ready,
    output logic                wr_req,
    input  logic                wr_valid,
    output logic                fifo_wr_en,
    output logic                rd_en,
    output logic                rd_valid,
    output logic                Next_Reg,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} top_e;
    typedef enum logic [2:0] {W_IDLE, W_WAIT, W_BURST, W_SETTLE, W_DONE} wr_e;
    typedef enum logic [2:0] {R_IDLE, R_WAIT, R_BURST, R_SETTLE, R_DONE} rd_e;

    localparam logic [ADDR_BITS:0]  LEN_ONE = 1;
    localparam logic [ROW_BITS-1:0] ROW_ONE = 1;

    top_e                top_q;
    wr_e                 wr_st_q;
    rd_e                 rd_st_q;
    logic [ROW_BITS-1:0] rows_q;
    logic [ADDR_BITS:0]  s_count_q, m_count_q;
    logic                busy_q, done_q, next_reg_q, rd_valid_q;
    logic [ADDR_BITS:0]  wr_cnt_q, rd_cnt_q;
    logic [ROW_BITS-1:0] wr_rows_q, rd_rows_q;
    logic                wr_set_q, rd_set_q;   // second SETTLE cycle marker

    logic accept, cfg_zero, go;

    assign accept   = start && (top_q == IDLE);
    assign cfg_zero = (cfg_rows == '0) || (cfg_wr_len == '0) || (cfg_rd_len == '0);
    // A degenerate config skips the engines entirely and goes straight to flush.
    assign go       = accept && !cfg_zero;

    // ---------------- top FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q      <= IDLE;
            rows_q     <= '0;
            s_count_q  <= '0;
            m_count_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            next_reg_q <= 1'b0;
        end else begin
            case (top_q)
                IDLE: if (accept) begin
                    rows_q    <= cfg_rows;
                    s_count_q <= cfg_wr_len;
                    m_count_q <= cfg_rd_len;
                    busy_q    <= 1'b1;
                    if (cfg_zero) begin
                        top_q      <= FLUSH;
                        next_reg_q <= 1'b1;
                    end else begin
                        top_q <= RUN;
                    end
                end
                RUN: if (wr_st_q == W_DONE && rd_st_q == R_DONE) begin
                    top_q      <= FLUSH;
                    next_reg_q <= 1'b1;
                end
                FLUSH: begin
                    top_q      <= DONE;
                    next_reg_q <= 1'b0;
                    done_q     <= 1'b1;
                end
                default: begin
                    top_q  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- write engine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_st_q   <= W_IDLE;
            wr_cnt_q  <= '0;
            wr_rows_q <= '0;
            wr_set_q  <= 1'b0;
        end else if (go) begin
            wr_st_q   <= W_WAIT;
            wr_cnt_q  <= '0;
            wr_rows_q <= '0;
            wr_set_q  <= 1'b0;
        end else begin
            case (wr_st_q)
                W_WAIT: if (S_Ready) wr_st_q <= W_BURST;
                W_BURST: if (wr_valid) begin
                    if (wr_cnt_q == s_count_q - LEN_ONE) begin
                        wr_cnt_q  <= '0;
                        wr_rows_q <= wr_rows_q + ROW_ONE;
                        wr_st_q   <= W_SETTLE;
                    end else begin
                        wr_cnt_q <= wr_cnt_q + LEN_ONE;
                    end
                end
                // Two cycles so the FIFO's registered S_Ready reflects this burst.
                W_SETTLE: begin
                    wr_set_q <= !wr_set_q;
                    if (wr_set_q)
                        wr_st_q <= (wr_rows_q == rows_q) ? W_DONE : W_WAIT;
                end
                W_DONE: if (top_q != RUN) wr_st_q <= W_IDLE;
                default: wr_st_q <= W_IDLE;
            endcase
        end
    end

    // ---------------- read engine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_st_q    <= R_IDLE;
            rd_cnt_q   <= '0;
            rd_rows_q  <= '0;
            rd_set_q   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= (rd_st_q == R_BURST);
            if (go) begin
                rd_st_q   <= R_WAIT;
                rd_cnt_q  <= '0;
                rd_rows_q <= '0;
                rd_set_q  <= 1'b0;
            end else begin
                case (rd_st_q)
                    R_WAIT: if (M_Ready) rd_st_q <= R_BURST;
                    // Data is guaranteed, so the burst has no gaps.
                    R_BURST: begin
                        if (rd_cnt_q == m_count_q - LEN_ONE) begin
                            rd_cnt_q  <= '0;
                            rd_rows_q <= rd_rows_q + ROW_ONE;
                            rd_st_q   <= R_SETTLE;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + LEN_ONE;
                        end
                    end
                    R_SETTLE: begin
                        rd_set_q <= !rd_set_q;
                        if (rd_set_q)
                            rd_st_q <= (rd_rows_q == rows_q) ? R_DONE : R_WAIT;
                    end
                    R_DONE: if (top_q != RUN) rd_st_q <= R_IDLE;
                    default: rd_st_q <= R_IDLE;
                endcase
            end
        end
    end

    assign S_count    = s_count_q;
    assign M_count    = m_count_q;
    assign wr_req     = (wr_st_q == W_BURST);
    assign fifo_wr_en = (wr_st_q == W_BURST) && wr_valid;
    assign rd_en      = (rd_st_q == R_BURST);
    assign rd_valid   = rd_valid_q;
    assign Next_Reg   = next_reg_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fifo_row_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fifo_row_sequencer
//   Directed bench for fifo_row_sequencer. Inputs change 1 time unit after the
//   rising edge; a negedge monitor accumulates per-layer statistics with cycle
//   offsets relative to the cycle right after the accepted start edge (rel 0).
// -----------------------------------------------------------------------------
module tb_fifo_row_sequencer;

    localparam int AB = 10;
    localparam int RB = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [RB-1:0] cfg_rows;
    logic [AB:0]   cfg_wr_len, cfg_rd_len;
    logic [AB:0]   S_count, M_count;
    logic          S_Ready, M_Ready;
    logic          wr_req, wr_valid, fifo_wr_en, rd_en, rd_valid;
    logic          Next_Reg, busy, done;

    fifo_row_sequencer #(.ADDR_BITS(AB), .ROW_BITS(RB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_rows(cfg_rows), .cfg_wr_len(cfg_wr_len), .cfg_rd_len(cfg_rd_len),
        .S_count(S_count), .M_count(M_count),
        .S_Ready(S_Ready), .M_Ready(M_Ready),
        .wr_req(wr_req), .wr_valid(wr_valid), .fifo_wr_en(fifo_wr_en),
        .rd_en(rd_en), .rd_valid(rd_valid), .Next_Reg(Next_Reg),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Time base advanced only here, so every input change lands 1 unit after an edge.
    int cyc = 0;
    int s0  = 0;
    int rel_c;
    int s_rel, m_rel;
    logic wv_tog, wv_lvl;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    always_comb begin
        rel_c    = cyc - s0;
        S_Ready  = (rel_c >= s_rel);
        M_Ready  = (rel_c >= m_rel);
        wr_valid = wv_tog ? rel_c[0] : wv_lvl;
    end

    // ---------------- monitor ----------------
    logic mon_rst, mon_on;
    int n_wr, n_wrreq, wr_runs, n_rd, rd_runs, rd_run_max, run_cur, n_rv;
    int bad_wr, bad_rv, n_nr, n_dn, n_busy, n_dn_busy;
    int t_fwr, t_wrreq, t_rd, t_nr, t_dn, t_idle;
    int s_cnt0, m_cnt0, busy0;
    logic wrq_p, rde_p;

    always @(negedge clk) begin
        if (mon_rst) begin
            n_wr <= 0; n_wrreq <= 0; wr_runs <= 0; n_rd <= 0; rd_runs <= 0;
            rd_run_max <= 0; run_cur <= 0; n_rv <= 0; bad_wr <= 0; bad_rv <= 0;
            n_nr <= 0; n_dn <= 0; n_busy <= 0; n_dn_busy <= 0;
            t_fwr <= -1; t_wrreq <= -1; t_rd <= -1; t_nr <= -1; t_dn <= -1; t_idle <= -1;
            s_cnt0 <= -1; m_cnt0 <= -1; busy0 <= -1;
            wrq_p <= 1'b0; rde_p <= 1'b0;
        end else if (mon_on) begin
            if (rel_c == 0) begin
                s_cnt0 <= int'(S_count); m_cnt0 <= int'(M_count); busy0 <= int'(busy);
            end
            if (fifo_wr_en) begin
                n_wr <= n_wr + 1;
                if (t_fwr < 0) t_fwr <= rel_c;
            end
            if (wr_req) begin
                n_wrreq <= n_wrreq + 1;
                if (!wrq_p) wr_runs <= wr_runs + 1;
                if (t_wrreq < 0) t_wrreq <= rel_c;
            end
            if (wr_req ? (fifo_wr_en !== wr_valid) : (fifo_wr_en !== 1'b0)) bad_wr <= bad_wr + 1;
            if (rd_en) begin
                n_rd <= n_rd + 1;
                if (!rde_p) rd_runs <= rd_runs + 1;
                if (t_rd < 0) t_rd <= rel_c;
                run_cur <= rde_p ? run_cur + 1 : 1;
                if ((rde_p ? run_cur + 1 : 1) > rd_run_max) rd_run_max <= rde_p ? run_cur + 1 : 1;
            end
            if (rd_valid) n_rv <= n_rv + 1;
            if (rd_valid !== rde_p) bad_rv <= bad_rv + 1;
            if (Next_Reg) begin
                n_nr <= n_nr + 1;
                if (t_nr < 0) t_nr <= rel_c;
            end
            if (done) begin
                n_dn <= n_dn + 1;
                if (t_dn < 0) t_dn <= rel_c;
                if (busy) n_dn_busy <= n_dn_busy + 1;
            end
            if (busy) n_busy <= n_busy + 1;
            else if (t_idle < 0) t_idle <= rel_c;
            wrq_p <= wr_req;
            rde_p <= rd_en;
        end
    end

    // Runs one layer until busy drops; inj pushes a second start at rel 5.
    task automatic run_layer(input int rows, input int wl, input int rl, input bit inj);
        bit finished;
        mon_rst = 1'b1;
        tick();
        mon_rst = 1'b0;
        cfg_rows = RB'(rows); cfg_wr_len = (AB+1)'(wl); cfg_rd_len = (AB+1)'(rl);
        start = 1'b1;
        tick();
        start = 1'b0;
        s0 = cyc;
        mon_on = 1'b1;
        finished = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (inj && rel_c == 5) begin
                cfg_rows = 12'd3; cfg_wr_len = 11'd6; cfg_rd_len = 11'd2;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (busy === 1'b0) begin
                finished = 1'b1;
                break;
            end
        end
        tick();
        mon_on = 1'b0;
        chk("layer_timeout", {31'd0, finished}, 32'd1);
    endtask

    function automatic logic [31:0] out_vec();
        return {3'd0, S_count, M_count, wr_req, fifo_wr_en, rd_en, rd_valid, Next_Reg, busy, done};
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_rows = '0; cfg_wr_len = '0; cfg_rd_len = '0;
        s_rel = 0; m_rel = 0; wv_tog = 1'b0; wv_lvl = 1'b1;
        mon_rst = 1'b1; mon_on = 1'b0;
        tick(); tick();
        chk("reset_outputs", out_vec(), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_outputs", out_vec(), 32'd0);

        // Basic layer: 2 rows x 4 words, both engines unthrottled.
        run_layer(2, 4, 4, 1'b0);
        chk("basic_wr_words", n_wr, 8);
        chk("basic_wr_bursts", wr_runs, 2);
        chk("basic_wr_en_eq_valid", bad_wr, 0);
        chk("basic_rd_words", n_rd, 8);
        chk("basic_rd_bursts", rd_runs, 2);
        chk("basic_rd_burst_len", rd_run_max, 4);
        chk("basic_rd_valid_cnt", n_rv, 8);
        chk("basic_rd_valid_lag", bad_rv, 0);
        chk("basic_first_wr", t_fwr, 1);
        chk("basic_first_rd", t_rd, 1);
        chk("basic_busy0", busy0, 1);
        chk("basic_nreg_cnt", n_nr, 1);
        chk("basic_nreg_time", t_nr, 15);
        chk("basic_done_cnt", n_dn, 1);
        chk("basic_done_time", t_dn, 16);
        chk("basic_done_busy", n_dn_busy, 1);
        chk("basic_idle_time", t_idle, 17);
        chk("basic_busy_cycles", n_busy, 17);

        // Backpressure: S_Ready low rel 0..9, M_Ready low rel 0..13.
        s_rel = 10; m_rel = 14;
        run_layer(1, 4, 4, 1'b0);
        s_rel = 0; m_rel = 0;
        chk("bp_first_wrreq", t_wrreq, 11);
        chk("bp_first_rd", t_rd, 15);
        chk("bp_wr_words", n_wr, 4);
        chk("bp_rd_words", n_rd, 4);
        chk("bp_nreg_time", t_nr, 22);
        chk("bp_done_time", t_dn, 23);

        // Producer gaps: wr_valid high on odd rel cycles.
        wv_tog = 1'b1;
        run_layer(1, 5, 1, 1'b0);
        wv_tog = 1'b0;
        chk("gap_s_count", s_cnt0, 5);
        chk("gap_m_count", m_cnt0, 1);
        chk("gap_wr_words", n_wr, 5);
        chk("gap_wrreq_cycles", n_wrreq, 9);
        chk("gap_wrreq_runs", wr_runs, 1);
        chk("gap_wr_en_eq_valid", bad_wr, 0);
        chk("gap_rd_words", n_rd, 1);
        chk("gap_nreg_time", t_nr, 13);
        chk("gap_done_time", t_dn, 14);

        // Zero config: straight to flush.
        run_layer(0, 4, 4, 1'b0);
        chk("zrow_wrreq", n_wrreq, 0);
        chk("zrow_rd", n_rd, 0);
        chk("zrow_nreg_time", t_nr, 0);
        chk("zrow_done_time", t_dn, 1);
        chk("zrow_idle_time", t_idle, 2);
        run_layer(2, 0, 4, 1'b0);
        chk("zwl_wrreq", n_wrreq, 0);
        chk("zwl_rd", n_rd, 0);
        chk("zwl_nreg_time", t_nr, 0);
        chk("zwl_done_time", t_dn, 1);

        // Start while busy is ignored.
        run_layer(2, 4, 4, 1'b1);
        chk("inj_s_count", {21'd0, S_count}, 32'd4);
        chk("inj_m_count", {21'd0, M_count}, 32'd4);
        chk("inj_wr_words", n_wr, 8);
        chk("inj_rd_words", n_rd, 8);
        chk("inj_done_cnt", n_dn, 1);
        chk("inj_done_time", t_dn, 16);

        // Reset mid-burst, then a fresh basic layer.
        cfg_rows = 12'd2; cfg_wr_len = 11'd4; cfg_rd_len = 11'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        s0 = cyc;
        tick(); tick();
        chk("pre_rst_bursts", {30'd0, wr_req, rd_en}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", out_vec(), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_layer(2, 4, 4, 1'b0);
        chk("post_rst_wr_words", n_wr, 8);
        chk("post_rst_rd_words", n_rd, 8);
        chk("post_rst_nreg_time", t_nr, 15);
        chk("post_rst_done_time", t_dn, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
